// File: rtl/mem_port_arbiter.sv
// Shares one single-port, 1-cycle-latency SRAM between a fetch and a load/store requester.
// Round-robin on contention; one access per cycle with back-to-back grants.
module mem_port_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_gnt,
   output logic        inst_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic [3:0]  data_wen,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_gnt,
   output logic        data_ok,
   output logic [31:0] data_rdata,
   output logic        sram_en,
   output logic [3:0]  sram_wen,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata,
   output logic        stallreq
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_INST = 2'd1,
      OWN_DATA = 2'd2
   } owner_t;

   localparam logic LAST_INST = 1'b0;
   localparam logic LAST_DATA = 1'b1;

   owner_t      owner_r;
   owner_t      owner_next;
   logic        last_grant_r;
   logic        data_load_r;
   logic [31:0] inst_hold_r;
   logic [31:0] data_hold_r;
   logic        inst_win;
   logic        data_win;

   // Grant decision: a lone requester wins; on a tie the side not served last wins.
   always_comb begin
      inst_win = 1'b0;
      data_win = 1'b0;
      if (rst) begin
         inst_win = 1'b0;
         data_win = 1'b0;
      end else if (inst_req && data_req) begin
         if (last_grant_r == LAST_INST) begin
            data_win = 1'b1;
         end else begin
            inst_win = 1'b1;
         end
      end else if (inst_req) begin
         inst_win = 1'b1;
      end else if (data_req) begin
         data_win = 1'b1;
      end else begin
         inst_win = 1'b0;
         data_win = 1'b0;
      end
   end

   assign inst_gnt = inst_win;
   assign data_gnt = data_win;

   // SRAM port mux driven straight from the winning requester.
   always_comb begin
      sram_en    = 1'b0;
      sram_wen   = 4'b0000;
      sram_addr  = 32'h0000_0000;
      sram_wdata = 32'h0000_0000;
      if (data_win) begin
         sram_en    = 1'b1;
         sram_wen   = data_wen;
         sram_addr  = data_addr;
         sram_wdata = data_wdata;
      end else if (inst_win) begin
         sram_en    = 1'b1;
         sram_wen   = 4'b0000;
         sram_addr  = inst_addr;
         sram_wdata = 32'h0000_0000;
      end else begin
         sram_en    = 1'b0;
      end
   end

   // Next owner is simply this cycle's winner, so every grant completes one cycle later.
   always_comb begin
      owner_next = OWN_NONE;
      case ({data_win, inst_win})
         2'b10:   owner_next = OWN_DATA;
         2'b01:   owner_next = OWN_INST;
         default: owner_next = OWN_NONE;
      endcase
   end

   // Ownership, round-robin history and held read data.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_r      <= OWN_NONE;
         last_grant_r <= LAST_INST;
         data_load_r  <= 1'b0;
         inst_hold_r  <= 32'h0000_0000;
         data_hold_r  <= 32'h0000_0000;
      end else begin
         owner_r <= owner_next;
         if (inst_win) begin
            last_grant_r <= LAST_INST;
         end else if (data_win) begin
            last_grant_r <= LAST_DATA;
         end else begin
            last_grant_r <= last_grant_r;
         end
         if (data_win) begin
            data_load_r <= (data_wen == 4'b0000);
         end else begin
            data_load_r <= data_load_r;
         end
         if (inst_ok) begin
            inst_hold_r <= sram_rdata;
         end else begin
            inst_hold_r <= inst_hold_r;
         end
         // A store completion leaves the last load value in place.
         if (data_ok && data_load_r) begin
            data_hold_r <= sram_rdata;
         end else begin
            data_hold_r <= data_hold_r;
         end
      end
   end

   // Reset in the current cycle suppresses any completion still owed from before it.
   always_comb begin
      inst_ok    = (owner_r == OWN_INST) && !rst;
      data_ok    = (owner_r == OWN_DATA) && !rst;
      inst_rdata = 32'h0000_0000;
      data_rdata = 32'h0000_0000;
      if (inst_ok) begin
         inst_rdata = sram_rdata;
      end else if (rst) begin
         inst_rdata = 32'h0000_0000;
      end else begin
         inst_rdata = inst_hold_r;
      end
      if (data_ok && data_load_r) begin
         data_rdata = sram_rdata;
      end else if (rst) begin
         data_rdata = 32'h0000_0000;
      end else begin
         data_rdata = data_hold_r;
      end
   end

   assign stallreq = !rst && ((inst_req && !inst_gnt) || (data_req && !data_gnt));

endmodule
